// File: rtl/fetch_pkg.sv
// Shared fetch-side constants: reset PC, instruction memory window, exception codes.
package fetch_pkg;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] IM_END   = 32'h0000_6FFF;
    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [31:0] NOP      = 32'h0;
endpackage

// File: rtl/ifq_ptr.sv
// Circular-buffer pointer with an extra wrap bit; reset and clear both return it to zero.
module ifq_ptr #(
    parameter int PW = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [PW-1:0] ptr
);
    always_ff @(posedge clk) begin
        if (reset || clear)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + PW'(1);
    end
endmodule

// File: rtl/if_fetch_queue.sv
// First-word fall-through instruction fetch queue between PC/IM and decode.
// Optional fetch address-error tagging is enabled by defining IFQ_EXC_EN.
module if_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AW-1:0]          in_pc,
    input  logic [DW-1:0]          in_instr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AW-1:0]          out_pc,
    output logic [DW-1:0]          out_instr,
`ifdef IFQ_EXC_EN
    output logic [4:0]             out_exc,
`endif
    output logic [$clog2(DEPTH):0] count
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          full, empty, push, pop;
    logic [DW-1:0] store_instr;

    logic [AW-1:0] pc_mem    [DEPTH];
    logic [DW-1:0] instr_mem [DEPTH];

    // Pointers differ only in the wrap bit when the buffer is full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);

    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign count     = wr_ptr - rd_ptr;

    ifq_ptr #(.PW(PW)) u_wr_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    ifq_ptr #(.PW(PW)) u_rd_ptr (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

`ifdef IFQ_EXC_EN
    localparam logic [AW-1:0] BASE = AW'(IM_BASE);
    localparam logic [AW-1:0] LAST = AW'(IM_END);

    logic       bad_addr;
    logic [4:0] exc_mem [DEPTH];

    // Misaligned or out-of-window fetches carry AdEL and a nop in place of the word.
    assign bad_addr    = (in_pc[1:0] != 2'b00) || (in_pc < BASE) || (in_pc > LAST);
    assign store_instr = bad_addr ? DW'(NOP) : in_instr;

    always_ff @(posedge clk) begin
        if (push)
            exc_mem[wr_ptr[IW-1:0]] <= bad_addr ? EXC_ADEL : EXC_NONE;
    end

    assign out_exc = empty ? EXC_NONE : exc_mem[rd_ptr[IW-1:0]];
`else
    assign store_instr = in_instr;
`endif

    // Storage is not reset; an empty queue masks whatever it holds.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr[IW-1:0]]    <= in_pc;
            instr_mem[wr_ptr[IW-1:0]] <= store_instr;
        end
    end

    assign out_pc    = empty ? '0 : pc_mem[rd_ptr[IW-1:0]];
    assign out_instr = empty ? DW'(NOP) : instr_mem[rd_ptr[IW-1:0]];
endmodule

// File: tb/tb_if_fetch_queue.sv
// Scoreboard bench for if_fetch_queue: a reference queue predicts every head/occupancy value.
module tb_if_fetch_queue;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic          in_ready, out_valid;
    logic [AW-1:0] in_pc, out_pc;
    logic [DW-1:0] in_instr, out_instr;
    logic [2:0]    count;
`ifdef IFQ_EXC_EN
    logic [4:0]    out_exc;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
    } entry_t;

    entry_t sb[$];
    int tests = 0;
    int fails = 0;

    if_fetch_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
`ifdef IFQ_EXC_EN
        .out_exc   (out_exc),
`endif
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return ~pc ^ 32'h1357_9BDF;
    endfunction

    function automatic entry_t make_entry(input logic [31:0] pc);
        entry_t e;
        e.pc    = pc;
        e.instr = instr_of(pc);
        e.exc   = 5'd0;
`ifdef IFQ_EXC_EN
        if (pc[1:0] != 2'b00 || pc < 32'h3000 || pc > 32'h6FFF) begin
            e.instr = 32'h0;
            e.exc   = 5'd4;
        end
`endif
        return e;
    endfunction

    // One clock: drive inputs, compare outputs against the model, then advance the model.
    task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                        input logic fl, input logic rst);
        logic do_push, do_pop;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = instr_of(pc);
        out_ready = rdy;
        flush     = fl;
        reset     = rst;
        #1;
        chk("in_ready", in_ready, sb.size() < DEPTH);
        chk("out_valid", out_valid, sb.size() != 0);
        chk("count", count, sb.size());
        chk("out_pc", out_pc, sb.size() != 0 ? sb[0].pc : 32'h0);
        chk("out_instr", out_instr, sb.size() != 0 ? sb[0].instr : 32'h0);
`ifdef IFQ_EXC_EN
        chk("out_exc", out_exc, sb.size() != 0 ? sb[0].exc : 5'd0);
`endif
        do_pop  = rdy && sb.size() != 0;
        do_push = v && sb.size() < DEPTH;
        if (rst || fl) begin
            sb.delete();
        end else begin
            if (do_pop) void'(sb.pop_front());
            if (do_push) sb.push_back(make_entry(pc));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_valid = 0; in_pc = '0; in_instr = '0; out_ready = 0; flush = 0; reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;

        // Reset state, then three pushes with decode stalled.
        step(0, 32'h0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 32'h3000 + 4 * i, 0, 0, 0);
        chk("t1_count", count, 3);
        chk("t1_head", out_pc, 32'h3000);

        // Fill to DEPTH, blocked 5th push, blocked push even while popping, then room again.
        step(1, 32'h300C, 0, 0, 0);
        chk("t2_full", in_ready, 0);
        step(1, 32'h3010, 0, 0, 0);
        step(1, 32'h3014, 1, 0, 0);
        chk("t2_ready_after_pop", in_ready, 1);
        chk("t2_count", count, 3);
        repeat (4) step(0, 32'h0, 1, 0, 0);

        // Steady push+pop across several pointer wraps.
        step(1, 32'h3000, 1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            step(1, 32'h3000 + 4 * i, 1, 0, 0);
            chk("t3_count", count, 1);
        end
        step(0, 32'h0, 1, 0, 0);

        // Flush overrides simultaneous push and pop.
        for (int i = 0; i < 3; i++) step(1, 32'h4000 + 4 * i, 0, 0, 0);
        step(1, 32'h5000, 1, 1, 0);
        chk("t4_count", count, 0);
        chk("t4_out_valid", out_valid, 0);
        chk("t4_out_pc", out_pc, 0);
        step(0, 32'h0, 0, 0, 0);

        // Reset mid-stream drops entries and ignores the concurrent push.
        for (int i = 0; i < 2; i++) step(1, 32'h6000 + 4 * i, 0, 0, 0);
        step(1, 32'h6100, 0, 0, 1);
        chk("t5_count", count, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_out_instr", out_instr, 0);

        // Address-check patterns; tagged only when the exception feature is built in.
        step(1, 32'h3002, 0, 0, 0);
        step(1, 32'h7000, 0, 0, 0);
        step(1, 32'h3004, 0, 0, 0);
        step(1, 32'h2FFC, 0, 0, 0);
        repeat (5) step(0, 32'h0, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
